// File: rtl/axi_slave_port_scheduler_if.sv
// Bundle of the per-slave scheduling signals: master requests, the muxed
// AXI handshakes seen at the slave, and the resulting grants.
//   slave modport  : used by the scheduler (requests/handshakes in, grants out)
//   master modport : used by whatever drives requests and handshakes
interface axi_slave_port_scheduler_if #(
  parameter int NUM_M     = 3,
  parameter int MIDX_BITS = 2
);
  logic [NUM_M-1:0]     rd_req;
  logic [NUM_M-1:0]     wr_req;
  logic                 arvalid_s, arready_s;
  logic                 awvalid_s, awready_s;
  logic                 wvalid_s, wready_s, wlast_s;
  logic                 rvalid_s, rready_s, rlast_s;
  logic                 bvalid_s, bready_s;
  logic [NUM_M-1:0]     rd_gnt;
  logic [NUM_M-1:0]     wr_gnt;
  logic [MIDX_BITS-1:0] rd_idx;
  logic [MIDX_BITS-1:0] wr_idx;
  logic                 busy;
  logic                 timeout_err;

  modport slave (
    input  rd_req, wr_req,
    input  arvalid_s, arready_s, awvalid_s, awready_s,
    input  wvalid_s, wready_s, wlast_s,
    input  rvalid_s, rready_s, rlast_s,
    input  bvalid_s, bready_s,
    output rd_gnt, wr_gnt, rd_idx, wr_idx, busy, timeout_err
  );

  modport master (
    output rd_req, wr_req,
    output arvalid_s, arready_s, awvalid_s, awready_s,
    output wvalid_s, wready_s, wlast_s,
    output rvalid_s, rready_s, rlast_s,
    output bvalid_s, bready_s,
    input  rd_gnt, wr_gnt, rd_idx, wr_idx, busy, timeout_err
  );
endinterface

// File: rtl/axi_slave_port_scheduler.sv
// Per-slave transaction scheduler: grants a single read or write transaction
// at a time to one of NUM_M masters, round-robin within each direction and
// alternating direction under contention. A watchdog releases a hung port.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - request/handshake inputs and registered grant outputs (slave modport)
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | no owner; arbitrate pending requests
// RD_ADDR | read granted, waiting for AR handshake
// RD_DATA | read data phase, waiting for last R beat
// WR_ADDR | write granted, waiting for AW (W may finish first)
// WR_DATA | AW done, waiting for last W beat
// WR_RESP | write data done, waiting for B handshake
module axi_slave_port_scheduler #(
  parameter int NUM_M     = 3,
  parameter int MIDX_BITS = 2,
  parameter int TIMEOUT   = 256
) (
  input logic clk,
  input logic rst,
  axi_slave_port_scheduler_if.slave bus
);

  localparam int WD = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

  state_t               state_q, state_d;
  logic [NUM_M-1:0]     rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic [MIDX_BITS-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [MIDX_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                 busy_q, busy_d, tmo_q, tmo_d;
  logic                 last_dir_q, last_dir_d, w_done_q, w_done_d;
  logic [WD-1:0]        wdog_q, wdog_d;

  logic ar_hs, aw_hs, w_hs, wl_hs, r_hs, rl_hs, b_hs, any_hs;
  logic [MIDX_BITS-1:0] rd_sel, wr_sel;

  // First requester strictly after ptr, wrapping; lowest offset wins.
  function automatic logic [MIDX_BITS-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                                   input logic [MIDX_BITS-1:0] ptr);
    logic [MIDX_BITS-1:0] sel;
    int k;
    sel = ptr;
    for (int i = NUM_M; i >= 1; i--) begin
      k = (int'(ptr) + i) % NUM_M;
      if (req[k]) sel = MIDX_BITS'(k);
    end
    return sel;
  endfunction

  assign ar_hs  = bus.arvalid_s & bus.arready_s;
  assign aw_hs  = bus.awvalid_s & bus.awready_s;
  assign w_hs   = bus.wvalid_s & bus.wready_s;
  assign wl_hs  = w_hs & bus.wlast_s;
  assign r_hs   = bus.rvalid_s & bus.rready_s;
  assign rl_hs  = r_hs & bus.rlast_s;
  assign b_hs   = bus.bvalid_s & bus.bready_s;
  assign any_hs = ar_hs | aw_hs | w_hs | r_hs | b_hs;

  assign rd_sel = rr_pick(bus.rd_req, rd_ptr_q);
  assign wr_sel = rr_pick(bus.wr_req, wr_ptr_q);

  always_comb begin
    state_d    = state_q;
    rd_gnt_d   = rd_gnt_q;
    wr_gnt_d   = wr_gnt_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    last_dir_d = last_dir_q;
    w_done_d   = w_done_q;
    wdog_d     = wdog_q;
    tmo_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // Under contention take the direction not served last time.
        if (|bus.rd_req && (!(|bus.wr_req) || last_dir_q == DIR_WR)) begin
          state_d    = RD_ADDR;
          rd_gnt_d   = NUM_M'(1) << rd_sel;
          rd_idx_d   = rd_sel + MIDX_BITS'(1);
          rd_ptr_d   = rd_sel;
          last_dir_d = DIR_RD;
          wdog_d     = '0;
        end else if (|bus.wr_req) begin
          state_d    = WR_ADDR;
          wr_gnt_d   = NUM_M'(1) << wr_sel;
          wr_idx_d   = wr_sel + MIDX_BITS'(1);
          wr_ptr_d   = wr_sel;
          last_dir_d = DIR_WR;
          wdog_d     = '0;
        end
      end
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (rl_hs) state_d = IDLE;
      WR_ADDR: begin
        // Write data may complete before the address is accepted.
        if (wl_hs) w_done_d = 1'b1;
        if (aw_hs) state_d = (w_done_q || wl_hs) ? WR_RESP : WR_DATA;
      end
      WR_DATA: if (wl_hs) state_d = WR_RESP;
      WR_RESP: begin
        if (b_hs) begin
          state_d  = IDLE;
          w_done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (any_hs) wdog_d = '0;
      else if (wdog_q != '1) wdog_d = wdog_q + WD'(1);
      if (TIMEOUT != 0 && !any_hs && wdog_q == WD'(TIMEOUT - 1)) begin
        state_d  = IDLE;
        w_done_d = 1'b0;
        tmo_d    = 1'b1;
      end
    end

    // Ownership ends on the same edge that returns to IDLE.
    if (state_d == IDLE) begin
      rd_gnt_d = '0;
      wr_gnt_d = '0;
      rd_idx_d = '0;
      wr_idx_d = '0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_gnt_q   <= '0;
      wr_gnt_q   <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      rd_ptr_q   <= MIDX_BITS'(NUM_M - 1);
      wr_ptr_q   <= MIDX_BITS'(NUM_M - 1);
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      last_dir_q <= DIR_WR;
      w_done_q   <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
      last_dir_q <= last_dir_d;
      w_done_q   <= w_done_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.rd_gnt      = rd_gnt_q;
  assign bus.wr_gnt      = wr_gnt_q;
  assign bus.rd_idx      = rd_idx_q;
  assign bus.wr_idx      = wr_idx_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_axi_slave_port_scheduler.sv
// Directed bench for axi_slave_port_scheduler (NUM_M=3, TIMEOUT=16).
// Observed vector layout: {rd_gnt, rd_idx, wr_gnt, wr_idx, busy, timeout_err}.
module tb_axi_slave_port_scheduler;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic chk_en;

  axi_slave_port_scheduler_if #(.NUM_M(3), .MIDX_BITS(2)) ifc ();

  axi_slave_port_scheduler #(.NUM_M(3), .MIDX_BITS(2), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ((ifc.rd_gnt != 0 && ifc.wr_gnt != 0) || !$onehot0(ifc.rd_gnt) || !$onehot0(ifc.wr_gnt) ||
          ((ifc.rd_idx == 0) != (ifc.rd_gnt == 0)) || ((ifc.wr_idx == 0) != (ifc.wr_gnt == 0)) ||
          (ifc.busy != ((ifc.rd_gnt | ifc.wr_gnt) != 0))) begin
        bad++;
        $display("FAIL invariant t=%0t rd_gnt=%b wr_gnt=%b rd_idx=%0d wr_idx=%0d busy=%b",
                 $time, ifc.rd_gnt, ifc.wr_gnt, ifc.rd_idx, ifc.wr_idx, ifc.busy);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ifc.rd_req = '0;    ifc.wr_req = '0;
    ifc.arvalid_s = 0;  ifc.arready_s = 0;
    ifc.awvalid_s = 0;  ifc.awready_s = 0;
    ifc.wvalid_s = 0;   ifc.wready_s = 0;  ifc.wlast_s = 0;
    ifc.rvalid_s = 0;   ifc.rready_s = 0;  ifc.rlast_s = 0;
    ifc.bvalid_s = 0;   ifc.bready_s = 0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    logic [11:0] obs;
    rst = 1'b1;
    clear_inputs();
    #2;
    rst = 1'b0;
    #1;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== 12'b0) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", obs, 12'b0);
    end
    tick();
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== 12'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=%b", obs, 12'b0);
    end
  endtask

  task automatic test_single_read;
    logic [11:0] obs;
    logic [11:0] held;
    held = {3'b001, 2'd1, 3'b000, 2'd0, 1'b1, 1'b0};
    do_reset();
    ifc.rd_req = 3'b001;
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== held) begin bad++; $display("FAIL sr_grant got=%b want=%b", obs, held); end
    ifc.rd_req = 3'b000;
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== held) begin bad++; $display("FAIL sr_addr_wait got=%b want=%b", obs, held); end
    ifc.arvalid_s = 1; ifc.arready_s = 1;
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== held) begin bad++; $display("FAIL sr_ar got=%b want=%b", obs, held); end
    ifc.arvalid_s = 0; ifc.arready_s = 0;
    ifc.rvalid_s = 1;  ifc.rready_s = 1;
    for (int b = 1; b <= 4; b++) begin
      ifc.rlast_s = (b == 4);
      tick();
      obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
      total++;
      if (obs !== ((b < 4) ? held : 12'b0)) begin
        bad++;
        $display("FAIL sr_beat%0d got=%b want=%b", b, obs, (b < 4) ? held : 12'b0);
      end
    end
    clear_inputs();
  endtask

  task automatic test_read_rr;
    logic [11:0] obs;
    logic [11:0] exp;
    int exp_m[4] = '{0, 1, 2, 0};
    do_reset();
    ifc.rd_req = 3'b111;
    tick();
    for (int g = 0; g < 4; g++) begin
      exp = {3'(1 << exp_m[g]), 2'(exp_m[g] + 1), 3'b000, 2'd0, 1'b1, 1'b0};
      obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", g, obs, exp); end
      ifc.arvalid_s = 1; ifc.arready_s = 1;
      tick();
      ifc.arvalid_s = 0; ifc.arready_s = 0;
      ifc.rvalid_s = 1;  ifc.rready_s = 1;  ifc.rlast_s = 1;
      tick();
      ifc.rvalid_s = 0;  ifc.rready_s = 0;  ifc.rlast_s = 0;
      obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
      total++;
      if (obs !== 12'b0) begin bad++; $display("FAIL rr_gap%0d got=%b want=%b", g, obs, 12'b0); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_direction_alt;
    logic [11:0] obs;
    logic [11:0] rd_held;
    logic [11:0] wr_held;
    rd_held = {3'b001, 2'd1, 3'b000, 2'd0, 1'b1, 1'b0};
    wr_held = {3'b000, 2'd0, 3'b010, 2'd2, 1'b1, 1'b0};
    do_reset();
    ifc.rd_req = 3'b001;
    ifc.wr_req = 3'b010;
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== rd_held) begin bad++; $display("FAIL alt_read1 got=%b want=%b", obs, rd_held); end
    ifc.arvalid_s = 1; ifc.arready_s = 1;
    tick();
    ifc.arvalid_s = 0; ifc.arready_s = 0;
    ifc.rvalid_s = 1;  ifc.rready_s = 1;  ifc.rlast_s = 1;
    tick();
    ifc.rvalid_s = 0;  ifc.rready_s = 0;  ifc.rlast_s = 0;
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== wr_held) begin bad++; $display("FAIL alt_write got=%b want=%b", obs, wr_held); end
    ifc.awvalid_s = 1; ifc.awready_s = 1;
    tick();
    ifc.awvalid_s = 0; ifc.awready_s = 0;
    ifc.wvalid_s = 1;  ifc.wready_s = 1;  ifc.wlast_s = 1;
    tick();
    ifc.wvalid_s = 0;  ifc.wready_s = 0;  ifc.wlast_s = 0;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== wr_held) begin bad++; $display("FAIL alt_wresp got=%b want=%b", obs, wr_held); end
    ifc.bvalid_s = 1; ifc.bready_s = 1;
    tick();
    ifc.bvalid_s = 0; ifc.bready_s = 0;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== 12'b0) begin bad++; $display("FAIL alt_wdone got=%b want=%b", obs, 12'b0); end
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== rd_held) begin bad++; $display("FAIL alt_read2 got=%b want=%b", obs, rd_held); end
    clear_inputs();
  endtask

  task automatic test_w_before_aw;
    logic [11:0] obs;
    logic [11:0] held;
    held = {3'b000, 2'd0, 3'b100, 2'd3, 1'b1, 1'b0};
    do_reset();
    ifc.wr_req = 3'b100;
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== held) begin bad++; $display("FAIL wba_grant got=%b want=%b", obs, held); end
    ifc.wr_req = 3'b000;
    ifc.wvalid_s = 1; ifc.wready_s = 1; ifc.wlast_s = 1;
    tick();
    ifc.wvalid_s = 0; ifc.wready_s = 0; ifc.wlast_s = 0;
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== held) begin bad++; $display("FAIL wba_wait got=%b want=%b", obs, held); end
    ifc.awvalid_s = 1; ifc.awready_s = 1;
    tick();
    ifc.awvalid_s = 0; ifc.awready_s = 0;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== held) begin bad++; $display("FAIL wba_aw got=%b want=%b", obs, held); end
    // Only WR_RESP accepts B; a detour through WR_DATA would keep the grant.
    ifc.bvalid_s = 1; ifc.bready_s = 1;
    tick();
    ifc.bvalid_s = 0; ifc.bready_s = 0;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== 12'b0) begin bad++; $display("FAIL wba_b got=%b want=%b", obs, 12'b0); end
    clear_inputs();
  endtask

  task automatic test_aw_w_same;
    logic [11:0] obs;
    logic [11:0] held;
    held = {3'b000, 2'd0, 3'b001, 2'd1, 1'b1, 1'b0};
    do_reset();
    ifc.wr_req = 3'b001;
    tick();
    ifc.wr_req = 3'b000;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== held) begin bad++; $display("FAIL same_grant got=%b want=%b", obs, held); end
    ifc.awvalid_s = 1; ifc.awready_s = 1;
    ifc.wvalid_s = 1;  ifc.wready_s = 1;  ifc.wlast_s = 1;
    tick();
    clear_inputs();
    ifc.bvalid_s = 1;  ifc.bready_s = 1;
    tick();
    ifc.bvalid_s = 0;  ifc.bready_s = 0;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== 12'b0) begin bad++; $display("FAIL same_b got=%b want=%b", obs, 12'b0); end
  endtask

  task automatic test_watchdog;
    logic [11:0] obs;
    logic [11:0] held;
    logic [11:0] exp;
    held = {3'b010, 2'd2, 3'b000, 2'd0, 1'b1, 1'b0};
    do_reset();
    ifc.rd_req = 3'b010;
    tick();
    ifc.rd_req = 3'b000;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
      total++;
      if (obs !== held) begin bad++; $display("FAIL wd_hold%0d got=%b want=%b", c, obs, held); end
    end
    tick();
    exp = 12'b0000_0000_0001;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL wd_release got=%b want=%b", obs, exp); end
    tick();
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== 12'b0) begin bad++; $display("FAIL wd_pulse_end got=%b want=%b", obs, 12'b0); end
    ifc.rd_req = 3'b011;
    tick();
    exp = {3'b001, 2'd1, 3'b000, 2'd0, 1'b1, 1'b0};
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL wd_next_grant got=%b want=%b", obs, exp); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst;
    logic [11:0] obs;
    logic [11:0] exp;
    do_reset();
    ifc.rd_req = 3'b001;
    tick();
    ifc.rd_req = 3'b000;
    ifc.arvalid_s = 1; ifc.arready_s = 1;
    tick();
    ifc.arvalid_s = 0; ifc.arready_s = 0;
    ifc.rvalid_s = 1;  ifc.rready_s = 1;  ifc.rlast_s = 0;
    tick();
    tick();
    exp = {3'b001, 2'd1, 3'b000, 2'd0, 1'b1, 1'b0};
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rmb_before got=%b want=%b", obs, exp); end
    rst = 1'b0;
    #2;
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== 12'b0) begin bad++; $display("FAIL rmb_async got=%b want=%b", obs, 12'b0); end
    clear_inputs();
    #2;
    rst = 1'b1;
    ifc.rd_req = 3'b010;
    tick();
    exp = {3'b010, 2'd2, 3'b000, 2'd0, 1'b1, 1'b0};
    obs = {ifc.rd_gnt, ifc.rd_idx, ifc.wr_gnt, ifc.wr_idx, ifc.busy, ifc.timeout_err};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rmb_regrant got=%b want=%b", obs, exp); end
    clear_inputs();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_read_rr();
    test_direction_alt();
    test_w_before_aw();
    test_aw_w_same();
    test_watchdog();
    test_reset_mid_burst();
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
